// File: rtl/sobel_stream_filter.sv
// ==== sobel_stream_filter : streaming 3x3 Sobel edge filter, RGB in, three stallable outputs ====
// Revision 1.0 - initial release
`default_nettype none

module sobel_stream_filter #(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int PIX_W     = 8,
  parameter int SHIFT     = 2,
  parameter int THRESH_EN = 0,
  parameter int THRESH    = 128
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rgb_vld,
  input  logic [3*PIX_W-1:0] i_rgb_data,
  output logic               i_rgb_busy,
  input  logic               o_newR_busy,
  input  logic               o_newG_busy,
  input  logic               o_newB_busy,
  output logic               o_newR_vld,
  output logic               o_newG_vld,
  output logic               o_newB_vld,
  output logic [PIX_W-1:0]   o_newR_data,
  output logic [PIX_W-1:0]   o_newG_data,
  output logic [PIX_W-1:0]   o_newB_data
);

  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = $clog2(IMG_H);
  localparam int c_GW    = PIX_W + 4;
  localparam logic [PIX_W-1:0] c_THRESH = PIX_W'(THRESH);

  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [PIX_W-1:0]   r_lb0 [IMG_W];
  logic [PIX_W-1:0]   r_lb1 [IMG_W];
  logic [PIX_W-1:0]   r_win [3][3];
  logic               r_win_vld;
  logic               r_win_brd;
  logic               r_s1_vld;
  logic [PIX_W-1:0]   r_s1_res;
  logic               r_s2_vld;
  logic [PIX_W-1:0]   r_s2_data;
  logic [2:0]         r_sent;

  logic               w_accept;
  logic               w_win_adv;
  logic               w_s1_adv;
  logic               w_rel;
  logic [2:0]         w_ovld;
  logic [2:0]         w_xfer;
  logic [PIX_W-1:0]   w_gray;
  logic [1:0]         w_unused_frac;
  logic [c_GW-1:0]    w_left, w_right, w_top, w_bot;
  logic [c_GW-1:0]    w_gx, w_gy, w_ax, w_ay, w_abs, w_mag;
  logic [PIX_W-1:0]   w_sat;
  logic [PIX_W-1:0]   w_pix;
  logic [PIX_W-1:0]   w_res;

  // Output handshake: each channel clears its own vld once taken; S2 frees when all are taken.
  assign w_ovld = {3{r_s2_vld}} & ~r_sent;
  assign w_xfer = w_ovld & ~{o_newB_busy, o_newG_busy, o_newR_busy};
  assign w_rel  = r_s2_vld & (&(r_sent | w_xfer));

  assign w_s1_adv   = r_s1_vld & (~r_s2_vld | w_rel);
  assign w_win_adv  = r_win_vld & (~r_s1_vld | w_s1_adv);
  assign i_rgb_busy = r_win_vld & ~w_win_adv;
  assign w_accept   = i_rgb_vld & ~i_rgb_busy;

  assign {w_gray, w_unused_frac} = {2'b00, i_rgb_data[PIX_W-1:0]}
                                 + {1'b0, i_rgb_data[2*PIX_W-1:PIX_W], 1'b0}
                                 + {2'b00, i_rgb_data[3*PIX_W-1:2*PIX_W]};

  assign w_left  = c_GW'(r_win[0][0]) + (c_GW'(r_win[1][0]) << 1) + c_GW'(r_win[2][0]);
  assign w_right = c_GW'(r_win[0][2]) + (c_GW'(r_win[1][2]) << 1) + c_GW'(r_win[2][2]);
  assign w_top   = c_GW'(r_win[0][0]) + (c_GW'(r_win[0][1]) << 1) + c_GW'(r_win[0][2]);
  assign w_bot   = c_GW'(r_win[2][0]) + (c_GW'(r_win[2][1]) << 1) + c_GW'(r_win[2][2]);
  assign w_gx    = w_right - w_left;
  assign w_gy    = w_bot - w_top;
  assign w_ax    = w_gx[c_GW-1] ? -w_gx : w_gx;
  assign w_ay    = w_gy[c_GW-1] ? -w_gy : w_gy;
  assign w_abs   = w_ax + w_ay;
  assign w_mag   = w_abs >> SHIFT;
  assign w_sat   = (|w_mag[c_GW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];

  generate
    if (THRESH_EN != 0) begin : g_thresh
      assign w_pix = (w_sat >= c_THRESH) ? '1 : '0;
    end else begin : g_plain
      assign w_pix = w_sat;
    end
  endgenerate

  assign w_res = r_win_brd ? '0 : w_pix;

  // Line buffers hold the two previous rows; stale contents only reach masked border outputs.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= w_gray;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win_vld <= 1'b0;
      r_win_brd <= 1'b1;
      r_s1_vld  <= 1'b0;
      r_s1_res  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_sent    <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else begin
      if (w_accept) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= r_lb1[r_col];
        r_win[1][2] <= r_lb0[r_col];
        r_win[2][2] <= w_gray;
        r_win_brd   <= (r_row < c_ROW_W'(2)) || (r_col < c_COL_W'(2));
        if (r_col == c_COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_W'(IMG_H - 1)) ? '0 : r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
      r_win_vld <= w_accept | (r_win_vld & ~w_win_adv);

      if (w_win_adv) begin
        r_s1_res <= w_res;
      end
      r_s1_vld <= w_win_adv | (r_s1_vld & ~w_s1_adv);

      if (w_s1_adv) begin
        r_s2_vld  <= 1'b1;
        r_s2_data <= r_s1_res;
        r_sent    <= '0;
      end else if (w_rel) begin
        r_s2_vld <= 1'b0;
        r_sent   <= '0;
      end else begin
        r_sent <= r_sent | w_xfer;
      end
    end
  end

  assign o_newR_vld  = w_ovld[0];
  assign o_newG_vld  = w_ovld[1];
  assign o_newB_vld  = w_ovld[2];
  assign o_newR_data = r_s2_data;
  assign o_newG_data = r_s2_data;
  assign o_newB_data = r_s2_data;

endmodule

`default_nettype wire
